// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - shared constants and state type for the EX-stage ALU/mul-div control
package alu_md_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1001;
    localparam logic [3:0] C_NOR  = 4'b1100;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

endpackage

// File: rtl/alu_md_if.sv
// rtl/alu_md_if.sv - EX-stage instruction/result bundle between pipeline and ALU/mul-div control
interface alu_md_if #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
);
    logic              valid_in;
    logic [FUNC_W-1:0] func;
    logic [1:0]        alu_op;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic [CTRL_W-1:0] alu_control;
    logic [1:0]        sel_hilo;
    logic              stall;
    logic              md_busy;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic              err_illegal_func_code;
    logic              err_illegal_alu_op;
    logic              err_div_zero;

    modport master (
        output valid_in, func, alu_op, rs_val, rt_val,
        input  alu_control, sel_hilo, stall, md_busy, hi, lo,
               err_illegal_func_code, err_illegal_alu_op, err_div_zero
    );

    modport slave (
        input  valid_in, func, alu_op, rs_val, rt_val,
        output alu_control, sel_hilo, stall, md_busy, hi, lo,
               err_illegal_func_code, err_illegal_alu_op, err_div_zero
    );
endinterface

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - radix-2 shift-add multiply / restoring divide on operand magnitudes
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH);

    // hi_q/lo_q: accumulator/multiplier for multiply, remainder/quotient for divide
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, div_q, div_d, neg_q, neg_d, negr_q, negr_d, dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign shifted = {hi_q, lo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, m_q};

    always_comb begin
        hi_d = hi_q; lo_d = lo_q; m_d = m_q; cnt_d = cnt_q; run_d = run_q;
        div_d = div_q; neg_d = neg_q; negr_d = negr_q; dz_d = dz_q;
        if (start) begin
            div_d  = is_div;
            neg_d  = a_neg ^ b_neg;
            negr_d = a_neg;
            dz_d   = is_div & (b == '0);
            run_d  = !(is_div & (b == '0));
            cnt_d  = CW'(WIDTH - 1);
            m_d    = is_div ? b_mag : a_mag;
            hi_d   = (is_div & (b == '0)) ? a_mag : '0;
            lo_d   = !is_div ? b_mag : ((b == '0) ? '1 : a_mag);
        end else if (run_q) begin
            if (!div_q) begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0; lo_q <= '0; m_q <= '0; cnt_q <= '0; run_q <= 1'b0;
            div_q <= 1'b0; neg_q <= 1'b0; negr_q <= 1'b0; dz_q <= 1'b0;
        end else begin
            hi_q <= hi_d; lo_q <= lo_d; m_q <= m_d; cnt_q <= cnt_d; run_q <= run_d;
            div_q <= div_d; neg_q <= neg_d; negr_q <= negr_d; dz_q <= dz_d;
        end
    end

    assign done = run_q & (cnt_q == '0);
    assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    // remainder follows the dividend's sign, which also reproduces rs for divide by zero
    assign hi_res = div_q ? (negr_q ? -hi_q : hi_q) : prod[2*WIDTH-1:WIDTH];
    assign lo_res = dz_q ? '1 : (div_q ? (neg_q ? -lo_q : lo_q) : prod[WIDTH-1:0]);
endmodule

// File: rtl/alu_md_control.sv
// rtl/alu_md_control.sv - EX-stage ALU control decode, mul/div sequencer FSM, HI/LO and hazard stall
module alu_md_control
    import alu_md_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_md_if.slave bus
);
    md_state_e         state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              dz_q, dz_d;
    logic [FUNC_W-1:0] func;
    logic [3:0]        ctrl;
    logic [1:0]        sel;
    logic              ill_func, ill_op, md_class, busy, accept;
    logic              core_start, core_done, is_div, is_signed;
    logic [WIDTH-1:0]  core_hi, core_lo;

    assign func = bus.func;

    always_comb begin
        ctrl = C_AND; sel = SEL_ALU; ill_func = 1'b0; ill_op = 1'b0; md_class = 1'b0;
        case (bus.alu_op)
            OP_ADD: ctrl = C_ADD;
            OP_SUB: ctrl = C_SUB;
            OP_RTYPE: begin
                case (func)
                    F_ADD:  ctrl = C_ADD;
                    F_SUB:  ctrl = C_SUB;
                    F_AND:  ctrl = C_AND;
                    F_OR:   ctrl = C_OR;
                    F_XOR:  ctrl = C_XOR;
                    F_NOR:  ctrl = C_NOR;
                    F_SLT:  ctrl = C_SLT;
                    F_SLTU: ctrl = C_SLTU;
                    F_SLL:  ctrl = C_SLL;
                    F_SRL:  ctrl = C_SRL;
                    F_SRA:  ctrl = C_SRA;
                    F_JR:   ctrl = C_AND;
                    F_MFHI: begin sel = SEL_HI; md_class = 1'b1; end
                    F_MFLO: begin sel = SEL_LO; md_class = 1'b1; end
                    F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: md_class = 1'b1;
                    default: ill_func = 1'b1;
                endcase
            end
            default: ill_op = 1'b1;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign accept    = bus.valid_in & md_class & !busy;
    assign is_div    = (func == F_DIV) || (func == F_DIVU);
    assign is_signed = (func == F_MULT) || (func == F_DIV);

    always_comb begin
        state_d = state_q; hi_d = hi_q; lo_d = lo_q; dz_d = dz_q; core_start = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                case (func)
                    F_MTHI: hi_d = bus.rs_val;
                    F_MTLO: lo_d = bus.rs_val;
                    F_MULT, F_MULTU: begin core_start = 1'b1; dz_d = 1'b0; state_d = S_MUL; end
                    F_DIV, F_DIVU: begin
                        core_start = 1'b1;
                        dz_d       = (bus.rt_val == '0);
                        state_d    = (bus.rt_val == '0) ? S_DONE : S_DIV;
                    end
                    default: ;
                endcase
            end
            S_MUL, S_DIV: if (core_done) state_d = S_DONE;
            default: begin
                hi_d = core_hi; lo_d = core_lo; dz_d = 1'b0; state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE; hi_q <= '0; lo_q <= '0; dz_q <= 1'b0;
        end else begin
            state_q <= state_d; hi_q <= hi_d; lo_q <= lo_d; dz_q <= dz_d;
        end
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk(clk), .rst_n(rst_n), .start(core_start), .is_div(is_div), .is_signed(is_signed),
        .a(bus.rs_val), .b(bus.rt_val), .done(core_done), .hi_res(core_hi), .lo_res(core_lo)
    );

    assign bus.alu_control           = CTRL_W'(ctrl);
    assign bus.sel_hilo              = sel;
    assign bus.stall                 = bus.valid_in & md_class & busy;
    assign bus.md_busy               = busy;
    assign bus.hi                    = hi_q;
    assign bus.lo                    = lo_q;
    assign bus.err_illegal_func_code = ill_func;
    assign bus.err_illegal_alu_op    = ill_op;
    assign bus.err_div_zero          = (state_q == S_DONE) & dz_q;
endmodule

// File: tb/tb_alu_md_control.sv
// tb/tb_alu_md_control.sv - scoreboard bench for alu_md_control decode, stall and mul/div results
module tb_alu_md_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [63:0] sb_q[$];

    alu_md_if #(.WIDTH(32), .FUNC_W(6), .CTRL_W(4)) bus ();

    alu_md_control #(.WIDTH(32), .FUNC_W(6), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [5:0] dec_func [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                  6'h00, 6'h02, 6'h03, 6'h08, 6'h11, 6'h18, 6'h10, 6'h12};
    logic [3:0] dec_ctrl [16] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7, 4'h8,
                                  4'h4, 4'h5, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [1:0] dec_sel  [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                  2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [5:0] md_funcs [4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: begin p = sa * sb; return p; end
            6'h19: return {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb; qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [5:0] f, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_in = v; bus.func = f; bus.alu_op = op; bus.rs_val = a; bus.rt_val = b;
    endtask

    task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        drive(1'b1, f, 2'b10, a, b);
        #1;
        while (bus.stall && n < 200) begin
            n++;
            step();
        end
        check_val("issue_stall", {63'd0, bus.stall}, 64'd0);
        sb_q.push_back(md_model(f, a, b));
        step();
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check_val({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        end
    endtask

    task automatic wait_md(input string tag, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (bus.md_busy && cyc < 200) begin
            cyc++;
            step();
        end
        check_val({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        pop_check(tag);
    endtask

    initial begin
        int n;
        logic [5:0]  f;
        logic [31:0] a, b;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);
        step(); step();
        check_val("rst_busy", {63'd0, bus.md_busy}, 64'd0);
        check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check_val("rst_dz", {63'd0, bus.err_div_zero}, 64'd0);
        rst_n = 1'b1;
        step();

        drive(1'b1, 6'h20, 2'b10, 32'd0, 32'd0);
        #1;
        check_val("add_ctrl", 64'(bus.alu_control), 64'h2);
        check_val("add_stall", {63'd0, bus.stall}, 64'd0);
        drive(1'b1, 6'h20, 2'b11, 32'd0, 32'd0);
        #1;
        check_val("op11_err", {63'd0, bus.err_illegal_alu_op}, 64'd1);
        check_val("op11_ctrl", 64'(bus.alu_control), 64'h0);
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);
        #1;
        check_val("op00_ctrl", 64'(bus.alu_control), 64'h2);
        drive(1'b0, 6'h20, 2'b01, 32'd0, 32'd0);
        #1;
        check_val("op01_ctrl", 64'(bus.alu_control), 64'h6);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, dec_func[i], 2'b10, 32'd0, 32'd0);
            #1;
            check_val($sformatf("dec_%02h", dec_func[i]),
                      {57'd0, bus.err_illegal_func_code, bus.sel_hilo, bus.alu_control},
                      {57'd0, 1'b0, dec_sel[i], dec_ctrl[i]});
        end
        step();

        issue_md(6'h18, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_md("mult", 33);
        check_val("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        issue_md(6'h1B, 32'd100, 32'd7);
        drive(1'b1, 6'h12, 2'b10, 32'd0, 32'd0);
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            step();
        end
        check_val("mflo_stall_cycles", 64'(n), 64'd33);
        check_val("mflo_sel", 64'(bus.sel_hilo), 64'd2);
        check_val("divu_const", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
        pop_check("divu");
        step();
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);

        issue_md(6'h1A, 32'hFFFF_FFF9, 32'd2);
        wait_md("div_neg", 33);
        issue_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_md("div_min", 33);
        issue_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_md("multu_max", 33);

        issue_md(6'h1A, 32'd5, 32'd0);
        check_val("dz_pulse", {62'd0, bus.err_div_zero, bus.md_busy}, 64'd3);
        wait_md("div_zero", 1);
        check_val("dz_clear", {63'd0, bus.err_div_zero}, 64'd0);

        issue_md(6'h18, 32'd1234, 32'd5678);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", {63'd0, bus.md_busy}, 64'd0);
        check_val("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        drive(1'b1, 6'h11, 2'b10, 32'h1234_5678, 32'd0);
        #1;
        check_val("mthi_stall", {63'd0, bus.stall}, 64'd0);
        step();
        check_val("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        drive(1'b1, 6'h13, 2'b10, 32'h9ABC_DEF0, 32'd0);
        step();
        check_val("mtlo_hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);

        issue_md(6'h18, 32'd3, 32'd5);
        step();
        drive(1'b1, 6'h3F, 2'b10, 32'd0, 32'd0);
        #1;
        check_val("ill_func", {59'd0, bus.err_illegal_func_code, bus.alu_control},
                  {59'd0, 1'b1, 4'h0});
        check_val("ill_stall_busy", {62'd0, bus.stall, bus.md_busy}, 64'd1);
        drive(1'b1, 6'h20, 2'b10, 32'd0, 32'd0);
        #1;
        check_val("add_busy", {59'd0, bus.stall, bus.alu_control}, {59'd0, 1'b0, 4'h2});
        drive(1'b1, 6'h10, 2'b10, 32'd0, 32'd0);
        #1;
        check_val("mfhi_busy_stall", {61'd0, bus.stall, bus.sel_hilo}, {61'd0, 1'b1, 2'd1});
        drive(1'b0, 6'h20, 2'b00, 32'd0, 32'd0);
        wait_md("mult_ill", 32);

        for (int i = 0; i < 6; i++) begin
            f = md_funcs[$urandom_range(0, 3)];
            a = $urandom;
            b = (i % 2 == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            issue_md(f, a, b);
            wait_md($sformatf("rand%0d_%02h", i, f), (f[1] && b == 32'd0) ? 1 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
